// File: rtl/uv_mode_picker.sv
// Chroma intra UV mode picker: scores each candidate as rate*lambda + (sse << DISTO_SHIFT)
// through a three-edge pipeline and reports the minimum-score mode with a done pulse.
module uv_mode_picker #(
    parameter int NUM_MODES   = 4,
    parameter int MODE_W      = 2,
    parameter int RATE_W      = 24,
    parameter int LAMBDA_W    = 16,
    parameter int DISTO_SHIFT = 8,
    parameter int SCORE_W     = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LAMBDA_W-1:0] lambda,
    input  logic                cand_valid,
    input  logic [31:0]         cand_sse,
    input  logic [RATE_W-1:0]   cand_rate,
    output logic                busy,
    output logic                done,
    output logic [MODE_W-1:0]   best_mode,
    output logic [SCORE_W-1:0]  best_score,
    output logic [31:0]         best_sse
);
    localparam int PROD_W = RATE_W + LAMBDA_W;
    localparam int DIST_W = 32 + DISTO_SHIFT;
    localparam logic [MODE_W-1:0] LAST_IDX = MODE_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t               state_reg, state_next;
    logic [MODE_W-1:0]    cnt_reg;
    logic [LAMBDA_W-1:0]  lambda_reg;

    logic                 s1_valid_reg, s1_last_reg;
    logic [PROD_W-1:0]    s1_prod_reg;
    logic [DIST_W-1:0]    s1_dist_reg;
    logic [31:0]          s1_sse_reg;
    logic [MODE_W-1:0]    s1_idx_reg;

    logic                 s2_valid_reg, s2_last_reg;
    logic [SCORE_W-1:0]   s2_score_reg;
    logic [31:0]          s2_sse_reg;
    logic [MODE_W-1:0]    s2_idx_reg;

    logic                 done_reg;
    logic [MODE_W-1:0]    best_mode_reg;
    logic [SCORE_W-1:0]   best_score_reg;
    logic [31:0]          best_sse_reg;

    logic accept;
    logic last_cand;
    logic finish;

    // start has priority over everything, including a coincident candidate
    assign accept    = cand_valid && (state_reg == COLLECT) && !start;
    assign last_cand = accept && (cnt_reg == LAST_IDX);
    assign finish    = s2_valid_reg && s2_last_reg && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = COLLECT;
        end else begin
            case (state_reg)
                COLLECT: if (last_cand) state_next = DRAIN;
                DRAIN:   if (finish)    state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            lambda_reg <= '0;
        end else if (start) begin
            cnt_reg    <= '0;
            lambda_reg <= lambda;
        end else if (accept) begin
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

    // E0: product, shifted distortion, sse and index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_prod_reg  <= '0;
            s1_dist_reg  <= '0;
            s1_sse_reg   <= '0;
            s1_idx_reg   <= '0;
        end else begin
            s1_valid_reg <= accept;
            s1_last_reg  <= last_cand;
            if (accept) begin
                s1_prod_reg <= PROD_W'(cand_rate) * PROD_W'(lambda_reg);
                s1_dist_reg <= DIST_W'(cand_sse) << DISTO_SHIFT;
                s1_sse_reg  <= cand_sse;
                s1_idx_reg  <= cnt_reg;
            end
        end
    end

    // E1: score sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_score_reg <= '0;
            s2_sse_reg   <= '0;
            s2_idx_reg   <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg && !start;
            s2_last_reg  <= s1_last_reg;
            if (s1_valid_reg) begin
                s2_score_reg <= SCORE_W'(s1_prod_reg) + SCORE_W'(s1_dist_reg);
                s2_sse_reg   <= s1_sse_reg;
                s2_idx_reg   <= s1_idx_reg;
            end
        end
    end

    // E2: strict less-than keeps the lower index on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_reg       <= 1'b0;
            best_mode_reg  <= '0;
            best_score_reg <= '1;
            best_sse_reg   <= '0;
        end else begin
            done_reg <= finish;
            if (start) begin
                best_mode_reg  <= '0;
                best_score_reg <= '1;
                best_sse_reg   <= '0;
            end else if (s2_valid_reg && (s2_score_reg < best_score_reg)) begin
                best_mode_reg  <= s2_idx_reg;
                best_score_reg <= s2_score_reg;
                best_sse_reg   <= s2_sse_reg;
            end
        end
    end

    assign done       = done_reg;
    assign best_mode  = best_mode_reg;
    assign best_score = best_score_reg;
    assign best_sse   = best_sse_reg;

endmodule
